// File: rtl/wb_config_loader_pkg.sv
// wb_config_loader_pkg: shared types and constants for the Wishbone config loader.
//   state_e     - loader FSM states (READ exists only with WB_CONFIG_LOADER_READBACK_EN)
//   ERR_*       - error codes reported on err_code_o
//   cfg_word_t  - buffered {address, data} configuration pair
//   sat_inc16   - saturating 16-bit increment used by the word counter
package wb_config_loader_pkg;

`ifdef WB_CONFIG_LOADER_READBACK_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_ERR   = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ERR   = 2'd3
  } state_e;
`endif

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_MISMATCH = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } cfg_word_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/wb_config_loader_fifo.sv
// cfg_word_fifo: synchronous FIFO of cfg_word_t entries.
//   clk, rst_n      - clock, asynchronous active-low reset (empties the FIFO)
//   push_i/wdata_i  - write an entry (ignored when full)
//   pop_i/rdata_o   - rdata_o shows the head; pop_i removes it (ignored when empty)
//   flush_i         - discard all entries
//   full_o, empty_o, count_o - occupancy status
module cfg_word_fifo
  import wb_config_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  cfg_word_t                wdata_i,
  input  logic                     pop_i,
  output cfg_word_t                rdata_o,
  input  logic                     flush_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  cfg_word_t     mem_q [DEPTH];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic          push_en, pop_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count_o = wr_q - rd_q;
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign empty_o = (wr_q == rd_q);
  assign rdata_o = mem_q[rd_q[AW-1:0]];
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_en) wr_d = wr_q + 1'b1;
      if (pop_en)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en && !flush_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/wb_config_loader.sv
// wb_config_loader: buffers {addr, data} pairs from a valid/ready port and
// issues one single-beat Wishbone write per pair, with timeout detection,
// sticky error reporting and a saturating completed-word counter.
// Optional macro WB_CONFIG_LOADER_READBACK_EN adds a read-back verify of
// every written word (mismatch reports err_code_o = 2).
// Ports:
//   wb_clk_i, wb_rst_ni            - clock, asynchronous active-low reset
//   cfg_valid_i/cfg_ready_o        - upstream handshake, cfg_addr_i/cfg_data_i payload
//   wbm_*                          - Wishbone initiator (all outputs registered)
//   busy_o, err_o, err_code_o      - status; err_clr_i clears the error and flushes
//   words_done_o                   - completed words, saturating at 16'hFFFF
module wb_config_loader
  import wb_config_loader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [31:0] cfg_addr_i,
  input  logic [31:0] cfg_data_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_data_o,
  input  logic [31:0] wbm_data_i,
  input  logic        wbm_ack_i,
  output logic        busy_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  input  logic        err_clr_i,
  output logic [15:0] words_done_o
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [9:0]  TMO_MAX = 10'(TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [9:0]  tmo_q, tmo_d;
  logic [1:0]  code_q, code_d;
  logic [15:0] words_q, words_d;
  logic        busy_q, busy_d;

  logic        push, pop, flush, full, empty;
  logic [AW:0] count, occ_nx;
  cfg_word_t   head;

  assign cfg_ready_o = wb_rst_ni & ~full & (state_q != ST_ERR);
  assign push        = cfg_valid_i & cfg_ready_o;

  cfg_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .push_i  (push),
    .wdata_i ({cfg_addr_i, cfg_data_i}),
    .pop_i   (pop),
    .rdata_o (head),
    .flush_i (flush),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

`ifndef WB_CONFIG_LOADER_READBACK_EN
  logic unused_rdata;
  assign unused_rdata = ^wbm_data_i;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    sel_d   = sel_q;
    tmo_d   = tmo_q;
    code_d  = code_q;
    words_d = words_q;
    pop     = 1'b0;
    flush   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          addr_d  = head.addr;
          data_d  = head.data;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          sel_d   = 4'hF;
          tmo_d   = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (wbm_ack_i) begin
`ifdef WB_CONFIG_LOADER_READBACK_EN
          // Drop the strobe for one cycle so the responder sees a fresh read cycle.
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          state_d = ST_READ;
`else
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          words_d = sat_inc16(words_q);
          state_d = ST_IDLE;
`endif
        end else if (tmo_q == TMO_MAX) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          code_d  = ERR_TIMEOUT;
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + 10'd1;
        end
      end
`ifdef WB_CONFIG_LOADER_READBACK_EN
      ST_READ: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
          tmo_d = '0;
        end else if (wbm_ack_i) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          sel_d = '0;
          if (wbm_data_i == data_q) begin
            words_d = sat_inc16(words_q);
            state_d = ST_IDLE;
          end else begin
            code_d  = ERR_MISMATCH;
            state_d = ST_ERR;
          end
        end else if (tmo_q == TMO_MAX) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          sel_d   = '0;
          code_d  = ERR_TIMEOUT;
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + 10'd1;
        end
      end
`endif
      ST_ERR: begin
        if (err_clr_i) begin
          flush   = 1'b1;
          code_d  = ERR_NONE;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Busy looks at next-cycle occupancy so it falls together with cyc.
    occ_nx = count + (AW+1)'(push) - (AW+1)'(pop);
    busy_d = (state_d == ST_WRITE)
`ifdef WB_CONFIG_LOADER_READBACK_EN
             || (state_d == ST_READ)
`endif
             || (!flush && (occ_nx != '0));
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      tmo_q   <= '0;
      code_q  <= ERR_NONE;
      words_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      tmo_q   <= tmo_d;
      code_q  <= code_d;
      words_q <= words_d;
      busy_q  <= busy_d;
    end
  end

  assign wbm_cyc_o    = cyc_q;
  assign wbm_stb_o    = stb_q;
  assign wbm_we_o     = we_q;
  assign wbm_sel_o    = sel_q;
  assign wbm_addr_o   = addr_q;
  assign wbm_data_o   = data_q;
  assign busy_o       = busy_q;
  assign err_o        = (state_q == ST_ERR);
  assign err_code_o   = code_q;
  assign words_done_o = words_q;

endmodule
